jtkunio_gfx_rom_server: RTL and testbench
=========================================

# jtkunio_gfx_rom_server

Memory-side responder for the three graphics ROM fetch ports of the Kunio video section: character, scroll and object. Each video client presents a word address and waits for `ok`. This block answers with 32-bit data from a single shared SDRAM read port. It keeps a one-entry cache per client, arbitrates misses by fixed priority, and runs one memory transaction at a time through a small state machine.

## Interface
Parameters:
- `CHAR_OFFSET`, 22'h00000: SDRAM word offset added to the char address.
- `SCR_OFFSET`, 22'h04000: SDRAM word offset added to the scroll address.
- `OBJ_OFFSET`, 22'h24000: SDRAM word offset added to the object address.

Ports:
- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: reset, synchronous, active-low.
- `char_addr`  in  14: char word address.
- `char_data`  out  32: char ROM data.
- `char_ok`  out  1: `char_data` is valid for the current `char_addr`.
- `scr_addr`  in  17: scroll word address.
- `scr_data`  out  32: scroll ROM data.
- `scr_ok`  out  1: `scr_data` is valid for the current `scr_addr`.
- `obj_addr`  in  18: object word address.
- `obj_cs`  in  1: object fetch enable.
- `obj_data`  out  32: object ROM data.
- `obj_ok`  out  1: `obj_data` is valid for the current `obj_addr`.
- `sdram_addr`  out  22: SDRAM word address.
- `sdram_req`  out  1: read request.
- `sdram_ack`  in  1: request accepted, 1-cycle pulse.
- `sdram_dst`  in  1: read data strobe, 1-cycle pulse.
- `sdram_data`  in  32: read data, sampled on `sdram_dst`.

## Operation
- **Per-slot cache.** Each slot holds `tag`, `data` and `valid`.
  - `ok` is combinational: `valid && tag == addr`.
  - For the object slot, `obj_ok` additionally requires `obj_cs`.
  - `data` outputs come straight from the cache registers.
- **Miss.** A slot misses when `!ok`. The object slot only counts as a miss while `obj_cs=1`.
- **Priority.** Fixed order, evaluated in IDLE only: scroll, then char, then obj.
- **Address formation.** `sdram_addr = OFFSET + zero-extended addr`, computed at 22 bits with wrap-around; no overflow is flagged.
- **States:**
  - IDLE: if any miss, latch the winning slot id and its address (`pend_addr`), drive `sdram_addr`, set `sdram_req=1`, go to WAIT_ACK.
  - WAIT_ACK: hold `sdram_req` and `sdram_addr`. On `sdram_ack`, clear `sdram_req` and go to WAIT_DATA.
  - WAIT_DATA: on `sdram_dst`, write `data<=sdram_data`, `tag<=pend_addr`, `valid<=1` into the latched slot, then go to IDLE.
- **Client moves mid-flight.** If the client address changes while its fetch is in flight, the returned data is still stored under `pend_addr`. `ok` stays low because the tag mismatches, so a new miss is served on the next IDLE.
- **Ack and data together.** `sdram_ack` and `sdram_dst` in the same WAIT_ACK cycle: the data is accepted, and the FSM goes straight to IDLE.
- **Stray strobe.** `sdram_dst` in IDLE or WAIT_ACK without an ack is ignored.
- **Object deselect.** Dropping `obj_cs` mid-fetch does not abort; the data is still written into the cache.
- **Reset (`rst=0`).** Synchronous, takes priority over everything:
  - all outputs and state return to their reset values (listed under Timing);
  - a transaction in flight is abandoned;
  - an `sdram_dst` arriving after reset is ignored.

## Timing
- **Reset values:** `sdram_req=0`, `sdram_addr=0`, all `valid=0`, all `ok=0`, all `data=0`, state IDLE.
- **Request issue:** a miss seen in IDLE at cycle N gives `sdram_req=1` at N+1.
- **Data return:** `sdram_dst` at cycle M gives `ok=1` and new data at M+1.
- **Minimum miss latency:** 3 cycles, miss to ok, with ack in the first cycle of WAIT_ACK and dst in the cycle after it.
- **Hit:** `ok` follows `addr` in the same cycle, with no added latency.
- **Back-to-back fetches:** one IDLE cycle separates consecutive transactions.

## Structure
- Package `jtkunio_gfx_pkg`:
  - state enum IDLE/WAIT_ACK/WAIT_DATA;
  - slot id constants SCR=0, CHAR=1, OBJ=2;
  - default offset constants.
- Sub-module `jtkunio_gfx_slot`, instantiated once per client: holds tag, data and valid, computes `ok`/miss, and takes a write port from the FSM.
- Top level contains the arbiter, the FSM and the address adder.

## Test plan
- **Reset then char miss.** Release reset, char_addr=14'h0123. Expect `sdram_req` with `sdram_addr`=22'h000123. Ack, then dst with 32'hDEADBEEF: `char_ok=1` and `char_data`=32'hDEADBEEF one cycle after dst.
- **Priority.** Scroll, char and obj (cs=1) all miss at once. Expect grants in the order scroll (`sdram_addr`=SCR_OFFSET+addr), char, obj, each separated by one IDLE cycle.
- **Address change mid-flight.** Char_addr changes 5→6 during WAIT_DATA. After dst, `char_ok=0` and a second request goes out for 6.
- **Object gating.** obj_cs=0 with a stale address: no request. Set obj_cs=1: request issued, `obj_ok=1` after dst. Drop obj_cs: `obj_ok=0` and the data is retained.
- **Reset mid-transaction.** Assert rst in WAIT_DATA: `sdram_req=0` and all `ok=0` the next cycle. A dst after release does not set any `valid`.
- **Simultaneous ack and dst, plus offset wrap.** ack and dst in the same cycle: returns to IDLE and `ok=1` the next cycle. OBJ_OFFSET=22'h3FFFFF with obj_addr=2: `sdram_addr`=22'h000001.

Source files
------------

// File: rtl/jtkunio_gfx_pkg.sv
// Shared types and constants for the Kunio graphics ROM server.
package jtkunio_gfx_pkg;
   typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

   localparam logic [1:0] SCR  = 2'd0;
   localparam logic [1:0] CHAR = 2'd1;
   localparam logic [1:0] OBJ  = 2'd2;

   localparam logic [21:0] CHAR_OFFSET_DEF = 22'h00000;
   localparam logic [21:0] SCR_OFFSET_DEF  = 22'h04000;
   localparam logic [21:0] OBJ_OFFSET_DEF  = 22'h24000;
endpackage

// File: rtl/jtkunio_gfx_slot.sv
// One-entry cache for a single graphics client: tag, data and valid.
module jtkunio_gfx_slot #(
   parameter int AW = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr,
   input  logic          cs,
   input  logic          wr,
   input  logic [AW-1:0] wr_tag,
   input  logic [31:0]   wr_data,
   output logic [31:0]   data,
   output logic          ok,
   output logic          miss
);
   logic [AW-1:0] tag;
   logic          valid;

   always_ff @(posedge clk) begin
      if (!rst) begin
         tag   <= '0;
         data  <= '0;
         valid <= 1'b0;
      end else if (wr) begin
         tag   <= wr_tag;
         data  <= wr_data;
         valid <= 1'b1;
      end
   end

   assign ok   = valid && (tag == addr) && cs;
   assign miss = cs && !ok;
endmodule

// File: rtl/jtkunio_gfx_rom_server.sv
// Serves char/scroll/object ROM fetches from one SDRAM read port,
// with a one-entry cache per client and fixed-priority miss arbitration.
module jtkunio_gfx_rom_server
   import jtkunio_gfx_pkg::*;
#(
   parameter logic [21:0] CHAR_OFFSET = CHAR_OFFSET_DEF,
   parameter logic [21:0] SCR_OFFSET  = SCR_OFFSET_DEF,
   parameter logic [21:0] OBJ_OFFSET  = OBJ_OFFSET_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] char_addr,
   output logic [31:0] char_data,
   output logic        char_ok,
   input  logic [16:0] scr_addr,
   output logic [31:0] scr_data,
   output logic        scr_ok,
   input  logic [17:0] obj_addr,
   input  logic        obj_cs,
   output logic [31:0] obj_data,
   output logic        obj_ok,
   output logic [21:0] sdram_addr,
   output logic        sdram_req,
   input  logic        sdram_ack,
   input  logic        sdram_dst,
   input  logic [31:0] sdram_data
);
   state_t      st;
   logic [1:0]  pend_slot;
   logic [17:0] pend_addr;
   logic        char_miss, scr_miss, obj_miss;
   logic        wr_en;

   // Data is accepted in WAIT_DATA, or in WAIT_ACK when ack and dst coincide.
   assign wr_en = sdram_dst && ((st == WAIT_DATA) || (st == WAIT_ACK && sdram_ack));

   jtkunio_gfx_slot #(.AW(17)) u_scr (
      .clk(clk), .rst(rst), .addr(scr_addr), .cs(1'b1),
      .wr(wr_en && pend_slot == SCR), .wr_tag(pend_addr[16:0]), .wr_data(sdram_data),
      .data(scr_data), .ok(scr_ok), .miss(scr_miss)
   );

   jtkunio_gfx_slot #(.AW(14)) u_char (
      .clk(clk), .rst(rst), .addr(char_addr), .cs(1'b1),
      .wr(wr_en && pend_slot == CHAR), .wr_tag(pend_addr[13:0]), .wr_data(sdram_data),
      .data(char_data), .ok(char_ok), .miss(char_miss)
   );

   jtkunio_gfx_slot #(.AW(18)) u_obj (
      .clk(clk), .rst(rst), .addr(obj_addr), .cs(obj_cs),
      .wr(wr_en && pend_slot == OBJ), .wr_tag(pend_addr), .wr_data(sdram_data),
      .data(obj_data), .ok(obj_ok), .miss(obj_miss)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         st         <= IDLE;
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         pend_slot  <= SCR;
         pend_addr  <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (scr_miss || char_miss || obj_miss) begin
                  sdram_req <= 1'b1;
                  st        <= WAIT_ACK;
                  if (scr_miss) begin
                     pend_slot  <= SCR;
                     pend_addr  <= {1'b0, scr_addr};
                     sdram_addr <= SCR_OFFSET + 22'(scr_addr);
                  end else if (char_miss) begin
                     pend_slot  <= CHAR;
                     pend_addr  <= {4'd0, char_addr};
                     sdram_addr <= CHAR_OFFSET + 22'(char_addr);
                  end else begin
                     pend_slot  <= OBJ;
                     pend_addr  <= obj_addr;
                     sdram_addr <= OBJ_OFFSET + 22'(obj_addr);
                  end
               end
            end
            WAIT_ACK: begin
               if (sdram_ack) begin
                  sdram_req <= 1'b0;
                  st        <= sdram_dst ? IDLE : WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               if (sdram_dst) st <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_jtkunio_gfx_rom_server.sv
// Directed bench for jtkunio_gfx_rom_server; object offset set to wrap.
module tb_jtkunio_gfx_rom_server;
   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] char_addr;
   logic [31:0] char_data;
   logic        char_ok;
   logic [16:0] scr_addr;
   logic [31:0] scr_data;
   logic        scr_ok;
   logic [17:0] obj_addr;
   logic        obj_cs;
   logic [31:0] obj_data;
   logic        obj_ok;
   logic [21:0] sdram_addr;
   logic        sdram_req;
   logic        sdram_ack;
   logic        sdram_dst;
   logic [31:0] sdram_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   jtkunio_gfx_rom_server #(.OBJ_OFFSET(22'h3FFFFF)) dut (
      .clk(clk), .rst(rst),
      .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
      .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
      .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_data(obj_data), .obj_ok(obj_ok),
      .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
      .sdram_dst(sdram_dst), .sdram_data(sdram_data)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ack_cycle(input string tag);
      sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0;
      chk({tag, "_req_clr"}, 32'(sdram_req), 32'd0);
   endtask

   task automatic dst_cycle(input logic [31:0] d);
      sdram_dst  = 1'b1;
      sdram_data = d;
      step();
      sdram_dst  = 1'b0;
      sdram_data = 32'h0;
   endtask

   initial begin
      rst = 1'b0; char_addr = '0; scr_addr = '0; obj_addr = '0; obj_cs = 1'b0;
      sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_data = '0;
      repeat (3) step();
      chk("rst_req", 32'(sdram_req), 32'd0);
      chk("rst_addr", 32'(sdram_addr), 32'd0);
      chk("rst_ok", {29'd0, scr_ok, char_ok, obj_ok}, 32'd0);
      chk("rst_data", scr_data | char_data | obj_data, 32'd0);

      // Scroll wins first after reset, then the char miss.
      scr_addr = 17'h00010; char_addr = 14'h0123; obj_addr = 18'h2;
      rst = 1'b1;
      step();
      chk("scr_req", 32'(sdram_req), 32'd1);
      chk("scr_addr", 32'(sdram_addr), 32'h004010);
      ack_cycle("scr");
      dst_cycle(32'h11112222);
      chk("scr_ok", 32'(scr_ok), 32'd1);
      chk("scr_data", scr_data, 32'h11112222);
      chk("char_pending", 32'(char_ok), 32'd0);
      step();
      chk("char_req", 32'(sdram_req), 32'd1);
      chk("char_addr", 32'(sdram_addr), 32'h000123);
      ack_cycle("char");
      dst_cycle(32'hDEADBEEF);
      chk("char_ok", 32'(char_ok), 32'd1);
      chk("char_data", char_data, 32'hDEADBEEF);

      // Hit path is combinational.
      scr_addr = 17'h00011; #1;
      chk("hit_miss", 32'(scr_ok), 32'd0);
      scr_addr = 17'h00010; #1;
      chk("hit_back", 32'(scr_ok), 32'd1);

      // All three miss together; char moves mid-flight.
      scr_addr = 17'h00020; char_addr = 14'h0005; obj_cs = 1'b1; obj_addr = 18'h2;
      step();
      chk("pri1_addr", 32'(sdram_addr), 32'h004020);
      ack_cycle("pri1");
      dst_cycle(32'hA0A0A0A0);
      chk("pri1_ok", 32'(scr_ok), 32'd1);
      step();
      chk("pri2_req", 32'(sdram_req), 32'd1);
      chk("pri2_addr", 32'(sdram_addr), 32'h000005);
      ack_cycle("pri2");
      char_addr = 14'h0006;
      dst_cycle(32'hB0B0B0B0);
      chk("move_ok", 32'(char_ok), 32'd0);
      step();
      chk("move_req", 32'(sdram_req), 32'd1);
      chk("move_addr", 32'(sdram_addr), 32'h000006);
      ack_cycle("move");
      dst_cycle(32'hC0C0C0C0);
      chk("move_ok2", 32'(char_ok), 32'd1);
      chk("move_data", char_data, 32'hC0C0C0C0);
      step();
      chk("pri3_req", 32'(sdram_req), 32'd1);
      chk("wrap_addr", 32'(sdram_addr), 32'h000001);

      // Ack and dst in the same cycle.
      sdram_ack = 1'b1; sdram_dst = 1'b1; sdram_data = 32'hD0D0D0D0;
      step();
      sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_data = 32'h0;
      chk("both_ok", 32'(obj_ok), 32'd1);
      chk("both_data", obj_data, 32'hD0D0D0D0);
      chk("both_req", 32'(sdram_req), 32'd0);
      step();
      chk("idle_noreq", 32'(sdram_req), 32'd0);

      // Object gating.
      obj_cs = 1'b0; #1;
      chk("cs0_ok", 32'(obj_ok), 32'd0);
      chk("cs0_data", obj_data, 32'hD0D0D0D0);
      obj_addr = 18'h3;
      step(); step();
      chk("cs0_noreq", 32'(sdram_req), 32'd0);
      obj_cs = 1'b1;
      step();
      chk("cs1_req", 32'(sdram_req), 32'd1);
      chk("cs1_addr", 32'(sdram_addr), 32'h000002);
      ack_cycle("cs1");
      dst_cycle(32'hE0E0E0E0);
      chk("cs1_ok", 32'(obj_ok), 32'd1);
      chk("cs1_data", obj_data, 32'hE0E0E0E0);

      // Deselect during the fetch still fills the cache.
      obj_addr = 18'h4;
      step();
      chk("desel_addr", 32'(sdram_addr), 32'h000003);
      ack_cycle("desel");
      obj_cs = 1'b0;
      dst_cycle(32'hF0F0F0F0);
      chk("desel_ok", 32'(obj_ok), 32'd0);
      chk("desel_data", obj_data, 32'hF0F0F0F0);
      obj_cs = 1'b1; #1;
      chk("resel_ok", 32'(obj_ok), 32'd1);
      obj_cs = 1'b0;

      // Reset while waiting for data.
      char_addr = 14'h0007;
      step();
      chk("rm_addr", 32'(sdram_addr), 32'h000007);
      ack_cycle("rm");
      rst = 1'b0;
      step();
      chk("rm_req", 32'(sdram_req), 32'd0);
      chk("rm_ok", {29'd0, scr_ok, char_ok, obj_ok}, 32'd0);
      chk("rm_data", scr_data | char_data | obj_data, 32'd0);
      rst = 1'b1;
      dst_cycle(32'h12345678);
      chk("stray_ok", {29'd0, scr_ok, char_ok, obj_ok}, 32'd0);
      chk("stray_data", scr_data | char_data, 32'd0);
      chk("post_req", 32'(sdram_req), 32'd1);
      chk("post_addr", 32'(sdram_addr), 32'h004020);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
